// File: rtl/mc_maindec_fsm.sv
// Moore control FSM for the RV32I multicycle datapath: sequences each
// instruction over 3-5 states and drives all datapath controls except ALU funct decode.
module mc_maindec_fsm #(
  parameter int SUPPORT_UTYPE = 1,
  parameter int SUPPORT_JALR  = 1,
  parameter int MEM_WAIT_EN   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pcwrite,
  output logic       o_adrsrc,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regwrite,
  output logic [1:0] o_resultsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_aluop,
  output logic [2:0] o_immsrc,
  output logic       o_illegal,
  output logic       o_instr_done,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BEQ, JAL, JALR1, JALR2, LUI, AUIPC, TRAP
  } state_t;

  typedef struct packed {
    logic       adrsrc, memwrite, fetch, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;
    logic       pcupdate, branch, done, done_mem;
  } ctrl_t;

  state_t state, nxt;
  ctrl_t  ctrl;
  logic   illegal;
  logic   rdy, run;

  assign rdy = (MEM_WAIT_EN == 0) | i_mem_ready;
  assign run = ~i_rst;

  // Fixed per-state controls; the ready/zero-qualified ones are combined at the outputs.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.fetch = 1'b1; end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; c.done = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; c.done_mem = 1'b1; end
      EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      ALUWB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
      BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; c.done = 1'b1; end
      JAL, JALR2: begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      JALR1:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      LUI:      begin c.alusrca = 2'b11; c.alusrcb = 2'b01; end
      AUIPC:    begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (i_op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011: nxt = EXECR;
          7'b0010011: nxt = EXECI;
          7'b1100011: nxt = BEQ;
          7'b1101111: nxt = JAL;
          7'b1100111: nxt = (SUPPORT_JALR != 0) ? JALR1 : TRAP;
          7'b0110111: nxt = (SUPPORT_UTYPE != 0) ? LUI : TRAP;
          7'b0010111: nxt = (SUPPORT_UTYPE != 0) ? AUIPC : TRAP;
          default:    nxt = TRAP;
        endcase
      end
      MEMADR:   nxt = (i_op == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = rdy ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL, JALR2, LUI, AUIPC: nxt = ALUWB;
      ALUWB, BEQ: nxt = FETCH;
      JALR1:    nxt = JALR2;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  // Controls are registered alongside the state so they are glitch-free Moore outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= FETCH;
      ctrl    <= decode(FETCH);
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
      if (nxt == TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    o_immsrc = 3'b000;
    case (i_op)
      7'b0100011:             o_immsrc = 3'b001;
      7'b1100011:             o_immsrc = 3'b010;
      7'b1101111:             o_immsrc = 3'b011;
      7'b0110111, 7'b0010111: o_immsrc = 3'b100;
      default:                o_immsrc = 3'b000;
    endcase
    if (!run) o_immsrc = 3'b000;
  end

  // Reset forces every output low so an abandoned instruction issues no write.
  assign o_irwrite    = run & ctrl.fetch & rdy;
  assign o_pcwrite    = run & ((ctrl.fetch & rdy) | ctrl.pcupdate | (ctrl.branch & i_zero));
  assign o_adrsrc     = run & ctrl.adrsrc;
  assign o_memwrite   = run & ctrl.memwrite;
  assign o_regwrite   = run & ctrl.regwrite;
  assign o_resultsrc  = {2{run}} & ctrl.resultsrc;
  assign o_alusrca    = {2{run}} & ctrl.alusrca;
  assign o_alusrcb    = {2{run}} & ctrl.alusrcb;
  assign o_aluop      = {2{run}} & ctrl.aluop;
  assign o_instr_done = run & (ctrl.done | (ctrl.done_mem & rdy));
  assign o_illegal    = run & illegal;
  assign o_state      = {4{run}} & state;

endmodule

// File: tb/tb_mc_maindec_fsm.sv
// Directed bench for mc_maindec_fsm: per-cycle expected control vectors are
// queued as stimulus is driven and compared mid-cycle.
module tb_mc_maindec_fsm;
  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [6:0] op;

  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal, instr_done;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic [2:0] immsrc;
  logic [3:0] state;

  logic       n_pcwrite, n_adrsrc, n_memwrite, n_irwrite, n_regwrite, n_illegal, n_done;
  logic [1:0] n_resultsrc, n_alusrca, n_alusrcb, n_aluop;
  logic [2:0] n_immsrc;
  logic [3:0] n_state;

  int checks = 0;
  int failures = 0;
  logic [21:0] sb[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         BQ = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111,
                         LU = 7'b0110111, BAD = 7'b1111111;

  always #5 clk = ~clk;

  mc_maindec_fsm dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pcwrite(pcwrite), .o_adrsrc(adrsrc), .o_memwrite(memwrite), .o_irwrite(irwrite),
    .o_regwrite(regwrite), .o_resultsrc(resultsrc), .o_alusrca(alusrca), .o_alusrcb(alusrcb),
    .o_aluop(aluop), .o_immsrc(immsrc), .o_illegal(illegal), .o_instr_done(instr_done),
    .o_state(state)
  );

  mc_maindec_fsm #(.SUPPORT_JALR(0)) dut_nojalr (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pcwrite(n_pcwrite), .o_adrsrc(n_adrsrc), .o_memwrite(n_memwrite), .o_irwrite(n_irwrite),
    .o_regwrite(n_regwrite), .o_resultsrc(n_resultsrc), .o_alusrca(n_alusrca),
    .o_alusrcb(n_alusrcb), .o_aluop(n_aluop), .o_immsrc(n_immsrc), .o_illegal(n_illegal),
    .o_instr_done(n_done), .o_state(n_state)
  );

  // Expected outputs for a given state and the inputs present in that cycle.
  function automatic logic [21:0] model(logic r, logic [3:0] s, logic rdy, logic z, logic [6:0] o);
    logic pcw, irw, rw, mw, adr, dn, ill;
    logic [1:0] rs, a, b, ao;
    logic [2:0] imm;
    {pcw, irw, rw, mw, adr, dn, ill} = '0;
    {rs, a, b, ao} = '0;
    case (s)
      4'd0:  begin b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; dn = rdy; end
      4'd6:  begin a = 2'b10; ao = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      4'd8:  begin rw = 1'b1; dn = 1'b1; end
      4'd9:  begin a = 2'b10; ao = 2'b01; dn = 1'b1; pcw = z; end
      4'd10, 4'd12: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      4'd11: begin a = 2'b10; b = 2'b01; end
      4'd13: begin a = 2'b11; b = 2'b01; end
      4'd14: begin a = 2'b01; b = 2'b01; end
      default: ill = 1'b1;
    endcase
    case (o)
      SW:      imm = 3'b001;
      BQ:      imm = 3'b010;
      JL:      imm = 3'b011;
      LU, 7'b0010111: imm = 3'b100;
      default: imm = 3'b000;
    endcase
    if (r) return '0;
    return {s, pcw, irw, rw, mw, adr, dn, ill, rs, a, b, ao, imm};
  endfunction

  // One clock cycle: drive, queue the expectation, compare at the falling edge.
  // n_st < 0 skips the check of the no-jalr instance.
  task automatic step(input string tag, input logic r, input logic [6:0] o, input logic rdy,
                      input logic z, input logic [3:0] st, input int n_st = -1,
                      input logic n_ill = 1'b0);
    logic [21:0] exp, obs;
    rst = r; op = o; mem_ready = rdy; zero = z;
    sb.push_back(model(r, st, rdy, z, o));
    @(negedge clk);
    exp = sb.pop_front();
    obs = {state, pcwrite, irwrite, regwrite, memwrite, adrsrc, instr_done, illegal,
           resultsrc, alusrca, alusrcb, aluop, immsrc};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    if (n_st >= 0) begin
      checks++;
      assert ({n_state, n_illegal} === {n_st[3:0], n_ill}) else begin
        failures++;
        $error("FAIL %s_nojalr observed=%h expected=%h", tag, {n_state, n_illegal}, {n_st[3:0], n_ill});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step("reset", 1'b1, LW, 1'b1, 1'b0, 4'd0, 0, 1'b0);
    // lw: 5 cycles, regwrite and done only in MEMWB
    step("lw_fetch", 0, LW, 1, 0, 4'd0, 0, 0);
    step("lw_dec",   0, LW, 1, 0, 4'd1);
    step("lw_adr",   0, LW, 1, 0, 4'd2);
    step("lw_rd",    0, LW, 1, 0, 4'd3);
    step("lw_wb",    0, LW, 1, 0, 4'd4);
    // sw with memory stalling three cycles in MEMWRITE
    step("sw_fetch", 0, SW, 1, 0, 4'd0);
    step("sw_dec",   0, SW, 1, 0, 4'd1);
    step("sw_adr",   0, SW, 1, 0, 4'd2);
    for (int i = 0; i < 3; i++) step("sw_wait", 0, SW, 0, 0, 4'd5);
    step("sw_write", 0, SW, 1, 0, 4'd5);
    // fetch stall, ready ignored outside memory states
    step("fetch_wait", 0, BQ, 0, 1, 4'd0);
    step("beq1_fetch", 0, BQ, 1, 1, 4'd0);
    step("beq1_dec",   0, BQ, 0, 1, 4'd1);
    step("beq1_taken", 0, BQ, 0, 1, 4'd9);
    step("beq0_fetch", 0, BQ, 1, 0, 4'd0);
    step("beq0_dec",   0, BQ, 1, 0, 4'd1);
    step("beq0_not",   0, BQ, 1, 0, 4'd9);
    // R-type, jal, lui
    step("r_fetch", 0, RT, 1, 0, 4'd0);
    step("r_dec",   0, RT, 1, 0, 4'd1);
    step("r_exec",  0, RT, 1, 0, 4'd6);
    step("r_wb",    0, RT, 1, 0, 4'd8);
    step("jal_fetch", 0, JL, 1, 0, 4'd0);
    step("jal_dec",   0, JL, 1, 0, 4'd1);
    step("jal_pc",    0, JL, 1, 0, 4'd10);
    step("jal_wb",    0, JL, 1, 0, 4'd8);
    step("lui_fetch", 0, LU, 1, 0, 4'd0);
    step("lui_dec",   0, LU, 1, 0, 4'd1);
    step("lui_ex",    0, LU, 1, 0, 4'd13);
    step("lui_wb",    0, LU, 1, 0, 4'd8);
    // jalr: supported instance walks 0,1,11,12,8; the other traps and sticks
    step("jalr_fetch", 0, JR, 1, 0, 4'd0, 0, 0);
    step("jalr_dec",   0, JR, 1, 0, 4'd1, 1, 0);
    step("jalr_1",     0, JR, 1, 0, 4'd11, 15, 1);
    step("jalr_2",     0, JR, 1, 0, 4'd12, 15, 1);
    step("jalr_wb",    0, JR, 1, 0, 4'd8, 15, 1);
    // illegal opcode, then reset out of TRAP
    step("bad_fetch", 0, BAD, 1, 0, 4'd0, 15, 1);
    step("bad_dec",   0, BAD, 1, 0, 4'd1, 15, 1);
    step("trap",      0, BAD, 1, 1, 4'd15, 15, 1);
    step("trap_hold", 0, BAD, 1, 1, 4'd15, 15, 1);
    step("trap_rst",  1, BAD, 1, 1, 4'd0, 0, 0);
    step("post_rst",  0, LW, 1, 0, 4'd0, 0, 0);
    step("post_dec",  0, LW, 1, 0, 4'd1, 1, 0);
    // reset mid-instruction in MEMADR suppresses everything
    step("mid_rst",   1, LW, 1, 0, 4'd0, 0, 0);
    step("mid_fetch", 0, LW, 1, 0, 4'd0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
